// File: rtl/frame_data_shadow_reg.sv
// Per-row frame data register: pipelined frame writes load a shadow copy,
// and a commit strobe moves it to the active outputs so all rows switch together.
module frame_data_shadow_reg #(
  parameter int unsigned FRAME_BITS_PER_ROW = 32,
  parameter int unsigned ROW_SELECT_WIDTH   = 5,
  parameter int unsigned ROW                = 1,
  parameter int unsigned PIPE_STAGES        = 1,
  parameter int unsigned COUNT_WIDTH        = 8
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [FRAME_BITS_PER_ROW-1:0] FrameData_I,
  input  logic                          FrameStrobe_I,
  input  logic [ROW_SELECT_WIDTH-1:0]   RowSelect,
  input  logic                          Commit_I,
  input  logic                          ClearOverrun_I,
  output logic [FRAME_BITS_PER_ROW-1:0] FrameData_O,
  output logic [FRAME_BITS_PER_ROW-1:0] ShadowData_O,
  output logic                          ShadowFull_O,
  output logic                          Overrun_O,
  output logic [COUNT_WIDTH-1:0]        CommitCount_O
);

  localparam logic [ROW_SELECT_WIDTH-1:0] ROW_SEL = ROW_SELECT_WIDTH'(ROW);
  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_FULL  = 1'b1;

  logic                          w_stb;
  logic [ROW_SELECT_WIDTH-1:0]   w_row;
  logic [FRAME_BITS_PER_ROW-1:0] w_data;

  generate
    if (PIPE_STAGES == 0) begin : g_nopipe
      assign w_stb  = FrameStrobe_I;
      assign w_row  = RowSelect;
      assign w_data = FrameData_I;
    end else begin : g_pipe
      logic                          r_stb_q  [PIPE_STAGES];
      logic [ROW_SELECT_WIDTH-1:0]   r_row_q  [PIPE_STAGES];
      logic [FRAME_BITS_PER_ROW-1:0] r_data_q [PIPE_STAGES];

      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          for (int unsigned i = 0; i < PIPE_STAGES; i++) begin
            r_stb_q[i]  <= 1'b0;
            r_row_q[i]  <= '0;
            r_data_q[i] <= '0;
          end
        end else begin
          r_stb_q[0]  <= FrameStrobe_I;
          r_row_q[0]  <= RowSelect;
          r_data_q[0] <= FrameData_I;
          for (int unsigned i = 1; i < PIPE_STAGES; i++) begin
            r_stb_q[i]  <= r_stb_q[i-1];
            r_row_q[i]  <= r_row_q[i-1];
            r_data_q[i] <= r_data_q[i-1];
          end
        end
      end

      assign w_stb  = r_stb_q[PIPE_STAGES-1];
      assign w_row  = r_row_q[PIPE_STAGES-1];
      assign w_data = r_data_q[PIPE_STAGES-1];
    end
  endgenerate

  logic [0:0]                    r_state;
  logic [FRAME_BITS_PER_ROW-1:0] r_shadow;
  logic [FRAME_BITS_PER_ROW-1:0] r_active;
  logic                          r_overrun;
  logic [COUNT_WIDTH-1:0]        r_count;

  logic w_write;
  logic w_commit;

  assign w_write  = w_stb && (w_row == ROW_SEL);
  // Commit only takes effect when the shadow holds data; it uses the pre-edge shadow.
  assign w_commit = Commit_I && (r_state == S_FULL);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= S_EMPTY;
      r_shadow  <= '0;
      r_active  <= '0;
      r_overrun <= 1'b0;
      r_count   <= '0;
    end else begin
      if (w_write) begin
        r_shadow <= w_data;
      end
      if (w_commit) begin
        r_active <= r_shadow;
        r_count  <= r_count + COUNT_WIDTH'(1);
      end
      if (w_write) begin
        r_state <= S_FULL;
      end else if (w_commit) begin
        r_state <= S_EMPTY;
      end
      // Overwriting uncommitted data is an overrun; set has priority over clear.
      if (w_write && (r_state == S_FULL) && !w_commit) begin
        r_overrun <= 1'b1;
      end else if (ClearOverrun_I) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign FrameData_O   = r_active;
  assign ShadowData_O  = r_shadow;
  assign ShadowFull_O  = (r_state == S_FULL);
  assign Overrun_O     = r_overrun;
  assign CommitCount_O = r_count;

endmodule

// File: tb/tb_frame_data_shadow_reg.sv
// Bench for frame_data_shadow_reg: three instances (PIPE_STAGES 0, 1, 3) share
// the stimulus; a vector table drives the depth-1 unit, hand sequences cover the rest.
module tb_frame_data_shadow_reg;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [31:0] data = '0;
  logic        stb = 1'b0;
  logic [4:0]  row = '0;
  logic        cmt = 1'b0;
  logic        clr = 1'b0;

  logic [2:0][31:0] fd;
  logic [2:0][31:0] sd;
  logic [2:0]       full;
  logic [2:0]       ovr;
  logic [2:0][7:0]  cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  frame_data_shadow_reg #(.FRAME_BITS_PER_ROW(32), .ROW_SELECT_WIDTH(5), .ROW(1),
                          .PIPE_STAGES(0), .COUNT_WIDTH(8)) u_p0 (
    .CLK(CLK), .RST(RST), .FrameData_I(data), .FrameStrobe_I(stb), .RowSelect(row),
    .Commit_I(cmt), .ClearOverrun_I(clr), .FrameData_O(fd[0]), .ShadowData_O(sd[0]),
    .ShadowFull_O(full[0]), .Overrun_O(ovr[0]), .CommitCount_O(cnt[0]));

  frame_data_shadow_reg #(.FRAME_BITS_PER_ROW(32), .ROW_SELECT_WIDTH(5), .ROW(1),
                          .PIPE_STAGES(1), .COUNT_WIDTH(8)) u_p1 (
    .CLK(CLK), .RST(RST), .FrameData_I(data), .FrameStrobe_I(stb), .RowSelect(row),
    .Commit_I(cmt), .ClearOverrun_I(clr), .FrameData_O(fd[1]), .ShadowData_O(sd[1]),
    .ShadowFull_O(full[1]), .Overrun_O(ovr[1]), .CommitCount_O(cnt[1]));

  frame_data_shadow_reg #(.FRAME_BITS_PER_ROW(32), .ROW_SELECT_WIDTH(5), .ROW(1),
                          .PIPE_STAGES(3), .COUNT_WIDTH(8)) u_p3 (
    .CLK(CLK), .RST(RST), .FrameData_I(data), .FrameStrobe_I(stb), .RowSelect(row),
    .Commit_I(cmt), .ClearOverrun_I(clr), .FrameData_O(fd[2]), .ShadowData_O(sd[2]),
    .ShadowFull_O(full[2]), .Overrun_O(ovr[2]), .CommitCount_O(cnt[2]));

  typedef struct {
    logic        full;
    logic        ovr;
    logic [31:0] sh;
    logic [31:0] fr;
    logic [7:0]  cnt;
  } exp_t;

  typedef struct {
    logic        stb;
    logic [4:0]  row;
    logic [31:0] data;
    logic        cmt;
    logic        clr;
    exp_t        e;
  } vec_t;

  vec_t tbl[$];
  exp_t sb[$];

  function automatic vec_t mk(input logic s, input logic [4:0] r, input logic [31:0] d,
                              input logic c, input logic cl, input logic f, input logic o,
                              input logic [31:0] sh, input logic [31:0] fr, input logic [7:0] n);
    vec_t v;
    v.stb = s; v.row = r; v.data = d; v.cmt = c; v.clr = cl;
    v.e.full = f; v.e.ovr = o; v.e.sh = sh; v.e.fr = fr; v.e.cnt = n;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    stb = 1'b0; row = '0; data = '0; cmt = 1'b0; clr = 1'b0;
  endtask

  task automatic chk_zero(input int idx, input string tag);
    chk($sformatf("%s_fd%0d", tag, idx), fd[idx], 32'h0);
    chk($sformatf("%s_sd%0d", tag, idx), sd[idx], 32'h0);
    chk($sformatf("%s_full%0d", tag, idx), 32'(full[idx]), 32'h0);
    chk($sformatf("%s_ovr%0d", tag, idx), 32'(ovr[idx]), 32'h0);
    chk($sformatf("%s_cnt%0d", tag, idx), 32'(cnt[idx]), 32'h0);
  endtask

  // Called just after an edge; pulses reset in the middle of the cycle.
  task automatic rst_all();
    idle_inputs();
    #2 RST = 1'b1;
    #1 RST = 1'b0;
  endtask

  task automatic seq_load_commit(input int idx, input int lat);
    rst_all();
    stb = 1'b1; row = 5'd1; data = 32'hA5A5_0001;
    cycle();
    idle_inputs();
    for (int e = 0; e <= 3; e++) begin
      if (e > 0) cycle();
      chk($sformatf("lc_p%0d_full_e%0d", lat, e), 32'(full[idx]), 32'(e >= lat));
    end
    cmt = 1'b1;
    cycle();
    cmt = 1'b0;
    chk($sformatf("lc_p%0d_fd", lat), fd[idx], 32'hA5A5_0001);
    chk($sformatf("lc_p%0d_cnt", lat), 32'(cnt[idx]), 32'd1);
    chk($sformatf("lc_p%0d_full", lat), 32'(full[idx]), 32'd0);
  endtask

  task automatic seq_simul(input int idx, input int lat);
    rst_all();
    stb = 1'b1; row = 5'd1; data = 32'h11;
    cycle();
    idle_inputs();
    repeat (lat) cycle();
    chk($sformatf("sim_p%0d_pre_sh", lat), sd[idx], 32'h11);
    chk($sformatf("sim_p%0d_pre_full", lat), 32'(full[idx]), 32'd1);
    stb = 1'b1; row = 5'd1; data = 32'h22; cmt = (lat == 0);
    cycle();
    idle_inputs();
    for (int j = 1; j <= lat; j++) begin
      chk($sformatf("sim_p%0d_hold%0d", lat, j), sd[idx], 32'h11);
      cmt = (j == lat);
      cycle();
      cmt = 1'b0;
    end
    chk($sformatf("sim_p%0d_fd", lat), fd[idx], 32'h11);
    chk($sformatf("sim_p%0d_sh", lat), sd[idx], 32'h22);
    chk($sformatf("sim_p%0d_full", lat), 32'(full[idx]), 32'd1);
    chk($sformatf("sim_p%0d_ovr", lat), 32'(ovr[idx]), 32'd0);
    chk($sformatf("sim_p%0d_cnt", lat), 32'(cnt[idx]), 32'd2 - 32'd1);
  endtask

  initial begin
    exp_t e;
    // Expected state after each edge of the depth-1 unit (writes land one edge late).
    tbl.push_back(mk(1'b1,5'd1,32'hA5A50001,1'b0,1'b0, 1'b0,1'b0,32'h0,32'h0,8'd0));
    tbl.push_back(mk(1'b0,5'd0,32'h0,1'b0,1'b0, 1'b1,1'b0,32'hA5A50001,32'h0,8'd0));
    tbl.push_back(mk(1'b0,5'd0,32'h0,1'b0,1'b0, 1'b1,1'b0,32'hA5A50001,32'h0,8'd0));
    tbl.push_back(mk(1'b0,5'd0,32'h0,1'b1,1'b0, 1'b0,1'b0,32'hA5A50001,32'hA5A50001,8'd1));
    tbl.push_back(mk(1'b1,5'd2,32'hDEADBEEF,1'b0,1'b0, 1'b0,1'b0,32'hA5A50001,32'hA5A50001,8'd1));
    tbl.push_back(mk(1'b0,5'd0,32'h0,1'b0,1'b0, 1'b0,1'b0,32'hA5A50001,32'hA5A50001,8'd1));
    tbl.push_back(mk(1'b1,5'd1,32'h1,1'b0,1'b0, 1'b0,1'b0,32'hA5A50001,32'hA5A50001,8'd1));
    tbl.push_back(mk(1'b1,5'd1,32'h2,1'b0,1'b0, 1'b1,1'b0,32'h1,32'hA5A50001,8'd1));
    tbl.push_back(mk(1'b0,5'd0,32'h0,1'b0,1'b0, 1'b1,1'b1,32'h2,32'hA5A50001,8'd1));
    tbl.push_back(mk(1'b0,5'd0,32'h0,1'b1,1'b0, 1'b0,1'b1,32'h2,32'h2,8'd2));
    tbl.push_back(mk(1'b0,5'd0,32'h0,1'b0,1'b1, 1'b0,1'b0,32'h2,32'h2,8'd2));
    tbl.push_back(mk(1'b1,5'd1,32'h11,1'b0,1'b0, 1'b0,1'b0,32'h2,32'h2,8'd2));
    tbl.push_back(mk(1'b0,5'd0,32'h0,1'b0,1'b0, 1'b1,1'b0,32'h11,32'h2,8'd2));
    tbl.push_back(mk(1'b1,5'd1,32'h22,1'b0,1'b0, 1'b1,1'b0,32'h11,32'h2,8'd2));
    tbl.push_back(mk(1'b0,5'd0,32'h0,1'b1,1'b0, 1'b1,1'b0,32'h22,32'h11,8'd3));
    tbl.push_back(mk(1'b0,5'd0,32'h0,1'b0,1'b0, 1'b1,1'b0,32'h22,32'h11,8'd3));
    tbl.push_back(mk(1'b0,5'd0,32'h0,1'b1,1'b0, 1'b0,1'b0,32'h22,32'h22,8'd4));
    tbl.push_back(mk(1'b0,5'd0,32'h0,1'b1,1'b0, 1'b0,1'b0,32'h22,32'h22,8'd4));
    tbl.push_back(mk(1'b1,5'd1,32'h33,1'b0,1'b0, 1'b0,1'b0,32'h22,32'h22,8'd4));
    tbl.push_back(mk(1'b1,5'd1,32'h44,1'b0,1'b0, 1'b1,1'b0,32'h33,32'h22,8'd4));
    tbl.push_back(mk(1'b0,5'd0,32'h0,1'b0,1'b1, 1'b1,1'b1,32'h44,32'h22,8'd4));
    tbl.push_back(mk(1'b0,5'd0,32'h0,1'b1,1'b0, 1'b0,1'b1,32'h44,32'h44,8'd5));
    tbl.push_back(mk(1'b0,5'd0,32'h0,1'b0,1'b1, 1'b0,1'b0,32'h44,32'h44,8'd5));
    tbl.push_back(mk(1'b1,5'd1,32'h55,1'b0,1'b0, 1'b0,1'b0,32'h44,32'h44,8'd5));
    tbl.push_back(mk(1'b0,5'd0,32'h0,1'b1,1'b0, 1'b1,1'b0,32'h55,32'h44,8'd5));
    tbl.push_back(mk(1'b0,5'd0,32'h0,1'b1,1'b0, 1'b0,1'b0,32'h55,32'h55,8'd6));

    // Power-on reset, checked before any clock edge.
    #2 RST = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) chk_zero(i, "por");
    @(posedge CLK);
    #1 RST = 1'b0;

    foreach (tbl[i]) begin
      stb = tbl[i].stb; row = tbl[i].row; data = tbl[i].data;
      cmt = tbl[i].cmt; clr = tbl[i].clr;
      sb.push_back(tbl[i].e);
      cycle();
      e = sb.pop_front();
      chk($sformatf("v%0d_full", i), 32'(full[1]), 32'(e.full));
      chk($sformatf("v%0d_ovr", i), 32'(ovr[1]), 32'(e.ovr));
      chk($sformatf("v%0d_sh", i), sd[1], e.sh);
      chk($sformatf("v%0d_fd", i), fd[1], e.fr);
      chk($sformatf("v%0d_cnt", i), 32'(cnt[1]), 32'(e.cnt));
    end
    idle_inputs();

    // Mid-cycle reset with a frame in flight: outputs clear at once, nothing lands later.
    stb = 1'b1; row = 5'd1; data = 32'h66;
    cycle();
    idle_inputs();
    #3 RST = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) chk_zero(i, "midrst");
    RST = 1'b0;
    repeat (4) cycle();
    for (int i = 0; i < 3; i++) chk_zero(i, "postrst");

    seq_load_commit(0, 0);
    seq_load_commit(1, 1);
    seq_load_commit(2, 3);
    seq_simul(0, 0);
    seq_simul(1, 1);
    seq_simul(2, 3);

    // Commit while empty, then counter wrap on the depth-1 unit.
    rst_all();
    cmt = 1'b1;
    cycle();
    cmt = 1'b0;
    chk("empty_cmt_fd", fd[1], 32'h0);
    chk("empty_cmt_cnt", 32'(cnt[1]), 32'h0);
    chk("empty_cmt_full", 32'(full[1]), 32'h0);
    for (int i = 0; i < 256; i++) begin
      stb = 1'b1; row = 5'd1; data = 32'(i);
      cycle();
      idle_inputs();
      cycle();
      cmt = 1'b1;
      if (i == 255) begin
        e.cnt = 8'd0; e.fr = 32'd255;
        sb.push_back(e);
      end
      cycle();
      cmt = 1'b0;
      if (i == 254) begin
        chk("wrap_cnt_255", 32'(cnt[1]), 32'd255);
        chk("wrap_fd_254", fd[1], 32'd254);
      end
    end
    e = sb.pop_front();
    chk("wrap_cnt_0", 32'(cnt[1]), 32'(e.cnt));
    chk("wrap_fd_255", fd[1], e.fr);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
